// File: rtl/mips_mem_defs_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_defs
//   Definitions shared by the data-memory responder and the processor-side
//   initiator: responder FSM state encoding, counter width and the
//   address-error rule. This package has no ports.
// ---------------------------------------------------------------------------
package mips_mem_defs;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    // A request is in error when it is not word aligned or when its word
    // index falls outside a memory of 'depth' words.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input int unsigned depth);
        return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
//   DEPTH x 32-bit data storage with one synchronous write port and one
//   asynchronous read port sharing a single word address.
//
//   clk      in   clock, write happens on the rising edge
//   we_i     in   write enable
//   addr_i   in   word index for both read and write
//   wdata_i  in   write data
//   rdata_o  out  word currently stored at addr_i
// ---------------------------------------------------------------------------
module dmem_array
    import mips_mem_defs::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; its contents must survive a
    // reset of the responder, and a reset port would also prevent RAM
    // inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Single-outstanding load/store responder for a word-addressed data
//   memory. A request is captured in IDLE, held for WAIT_CYCLES wait states,
//   then answered in RESP until the initiator takes the response.
//
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active low
//   req_valid   in   initiator presents a request
//   req_ready   out  responder is idle and can accept a request
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   resp_valid  out  response available
//   resp_ready  in   initiator consumes the response
//   resp_rdata  out  load data, 0 for stores and errors
//   resp_err    out  request was misaligned or out of range
// ---------------------------------------------------------------------------
module mem_responder
    import mips_mem_defs::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned       AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    resp_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;

    // Captured request
    logic              we_q;
    logic              err_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;

    // Registered response
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [WORD_W-1:0] resp_rdata_q;

    logic              accept;
    logic              err_d;
    logic              to_resp;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign err_d     = addr_err(req_addr, DEPTH);

    // WAIT is left on the edge where the counter reads zero. It is loaded
    // with WAIT_CYCLES, so a request spends one settle cycle plus
    // WAIT_CYCLES wait states there and the response is presented
    // WAIT_CYCLES+1 edges after the accepting edge.
    assign to_resp = (state_q == WAIT) && (cnt_q == '0);

    // The single write of a store happens on the edge entering RESP. Gating
    // with rst keeps a store that is reset in flight out of the storage.
    assign mem_we = rst && to_resp && we_q && !err_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // NOTE: all state in this block is assigned with <= so every register
    // samples the values from before the edge, independent of statement
    // order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        err_q   <= err_d;
                        idx_q   <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (to_resp) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        // Stores and erroring requests return zero data; the
                        // read port value is only meaningful for a good load.
                        resp_rdata_q <= (we_q || err_q) ? '0 : mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Two responders: index 0 with DEPTH=256, WAIT_CYCLES=2 and index 1 with
//   DEPTH=16, WAIT_CYCLES=0. Requests are issued by a driver that computes
//   the expected response from a plain word-array model and pushes it into
//   a per-instance queue; an independent monitor pops and compares whenever
//   a response is presented, and also checks latency and hold stability.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int unsigned D0 = 256;
    localparam int unsigned W0 = 2;
    localparam int unsigned D1 = 16;
    localparam int unsigned W1 = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc_cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]      resp_err;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rr_mode [2];   // 0 random, 1 always ready, 2 never ready
    logic [31:0] model_mem [2][256];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];

    mem_responder #(.DEPTH(D0), .WAIT_CYCLES(W0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    mem_responder #(.DEPTH(D1), .WAIT_CYCLES(W1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        if (d == 0) return exp_q0.size();
        return exp_q1.size();
    endfunction

    function automatic exp_t qfront(input int d);
        if (d == 0) return exp_q0[0];
        return exp_q1[0];
    endfunction

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic qpop(input int d);
        exp_t dummy;
        if (d == 0) dummy = exp_q0.pop_front();
        else        dummy = exp_q1.pop_front();
    endtask

    // Called at posedge+#1; returns at posedge+#1 just after the accepting
    // edge. 'track'=0 leaves the model untouched (request will be aborted).
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit track, output int acc);
        exp_t        e;
        int unsigned depth;
        bit          got;
        depth = (d == 0) ? D0 : D1;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d accept_timeout: req_ready stayed 0, required 1 within 200 cycles", d);
            req_valid[d] = 1'b0;
            acc = -1;
            return;
        end
        acc       = cyc + 1;
        e.acc_cyc = acc;
        e.err     = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(depth));
        e.rdata   = '0;
        if (track && !e.err) begin
            if (we) model_mem[d][addr >> 2] = wdata;
            else    e.rdata = model_mem[d][addr >> 2];
        end
        if (track) qpush(d, e);
        @(posedge clk);
        #1;
        // Scramble the request lines; the captured request must not follow.
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
    endtask

    task automatic monitor(input int d);
        bit          prev_v = 1'b0;
        logic [31:0] held_rdata = '0;
        logic        held_err = 1'b0;
        exp_t        e;
        int          w;
        w = (d == 0) ? int'(W0) : int'(W1);
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 1'b0;
                continue;
            end
            if (resp_valid[d]) begin
                check($sformatf("dut%0d req_ready_in_resp", d), 32'(req_ready[d]), 32'd0);
                if (!prev_v) begin
                    if (qsize(d) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut%0d spurious_resp: resp_valid=1 with no request pending", d);
                    end else begin
                        e = qfront(d);
                        check($sformatf("dut%0d latency", d), 32'(cyc - e.acc_cyc), 32'(1 + w));
                        check($sformatf("dut%0d resp_err", d), 32'(resp_err[d]), 32'(e.err));
                        check($sformatf("dut%0d resp_rdata", d), resp_rdata[d], e.rdata);
                    end
                end else begin
                    check($sformatf("dut%0d hold_rdata", d), resp_rdata[d], held_rdata);
                    check($sformatf("dut%0d hold_err", d), 32'(resp_err[d]), 32'(held_err));
                end
                held_rdata = resp_rdata[d];
                held_err   = resp_err[d];
                if (resp_ready[d] && qsize(d) != 0) qpop(d);
            end
            prev_v = resp_valid[d];
        end
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && i < 1000) begin
            @(posedge clk);
            i++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d responses outstanding, required 0/0",
                     exp_q0.size(), exp_q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr(input int unsigned depth);
        int unsigned sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return ($urandom_range(0, depth - 1) << 2) | 32'($urandom_range(1, 3));
            1:       return (depth + $urandom_range(0, 15)) << 2;
            2:       return (depth - 1) << 2;
            3:       return $urandom | 32'h8000_0000;
            default: return $urandom_range(0, depth - 1) << 2;
        endcase
    endfunction

    task automatic random_traffic(input int d, input int n);
        int          acc;
        int unsigned depth;
        depth = (d == 0) ? D0 : D1;
        for (int i = 0; i < n; i++) begin
            issue(d, 1'($urandom), rand_addr(depth), $urandom, 1'b1, acc);
        end
    endtask

    task automatic fill_or_read(input int d, input logic we);
        int          acc;
        int unsigned depth;
        depth = (d == 0) ? D0 : D1;
        for (int unsigned i = 0; i < depth; i++) begin
            issue(d, we, i << 2, $urandom, 1'b1, acc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                case (rr_mode[d])
                    0:       resp_ready[d] = ($urandom_range(0, 3) != 0);
                    1:       resp_ready[d] = 1'b1;
                    default: resp_ready[d] = 1'b0;
                endcase
            end
        end
    end

    initial begin
        int          a1, a2, acc;
        logic [31:0] exp_val;
        bit          seen;

        rst        = 1'b0;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '0;
        rr_mode[0] = 0;
        rr_mode[1] = 0;
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("dut%0d reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
            check($sformatf("dut%0d reset resp_err", d), 32'(resp_err[d]), 32'd0);
            check($sformatf("dut%0d reset resp_rdata", d), resp_rdata[d], 32'd0);
        end
        @(posedge clk);
        #1;

        // Give every word a known value.
        fork
            fill_or_read(0, 1'b1);
            fill_or_read(1, 1'b1);
        join
        drain();

        // Store then load of the same word, back to back with ready held high.
        rr_mode[0] = 1;
        rr_mode[1] = 1;
        @(posedge clk);
        #1;
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, a1);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, a2);
        check("dut0 b2b_spacing", 32'(a2 - a1), 32'(W0 + 3));
        issue(1, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b1, a1);
        issue(1, 1'b0, 32'h10, 32'h0, 1'b1, a2);
        check("dut1 b2b_spacing", 32'(a2 - a1), 32'(W1 + 3));

        // Misaligned load, then the neighbouring good word.
        issue(0, 1'b0, 32'h13, 32'h0, 1'b1, acc);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, acc);

        // Stores just past the end of storage.
        issue(0, 1'b1, 32'h400, 32'h5555_AAAA, 1'b1, acc);
        issue(1, 1'b1, 32'h40, 32'h5555_AAAA, 1'b1, acc);
        issue(0, 1'b0, 32'h3FC, 32'h0, 1'b1, acc);
        issue(1, 1'b0, 32'h3C, 32'h0, 1'b1, acc);
        drain();

        // Response held off for five cycles.
        rr_mode[0] = 2;
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        exp_val = model_mem[0][4];
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("dut0 hold resp_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("dut0 hold resp_valid", 32'(resp_valid[0]), 32'd1);
            check("dut0 hold resp_rdata", resp_rdata[0], exp_val);
            check("dut0 hold req_ready", 32'(req_ready[0]), 32'd0);
        end
        rr_mode[0] = 1;
        @(posedge clk);
        #1;
        drain();

        // Reset while a store sits in WAIT: the store must be lost.
        issue(0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, acc);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("dut0 abort req_ready", 32'(req_ready[0]), 32'd1);
        check("dut0 abort resp_valid", 32'(resp_valid[0]), 32'd0);
        check("dut0 abort resp_err", 32'(resp_err[0]), 32'd0);
        check("dut0 abort resp_rdata", resp_rdata[0], 32'd0);
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h20, 32'h0, 1'b1, acc);
        drain();

        // Randomized traffic with random response back-pressure.
        rr_mode[0] = 0;
        rr_mode[1] = 0;
        fork
            random_traffic(0, 150);
            random_traffic(1, 150);
        join
        drain();

        // Read every word back against the model.
        rr_mode[0] = 1;
        rr_mode[1] = 1;
        @(posedge clk);
        #1;
        fork
            fill_or_read(0, 1'b0);
            fill_or_read(1, 1'b0);
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
